// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - shared state encodings and sizes for the round-robin mux arbiter
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// rtl/rr_mux_arbiter_mux.sv - 4-input, 4-bit multiplexer shared by the arbiter's requesters
module rr_mux_arbiter_mux (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    // plain 4:1 selection of the requester data
    always_comb begin
        y = a;
        case (sel)
            2'd0: y = a;
            2'd1: y = b;
            2'd2: y = c;
            2'd3: y = d;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter with hold timeout driving the shared result mux
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       valid,
    output logic [3:0] y,
    output logic       timeout
);

    // Returns {found, index}: first set bit of r scanning p, p+1, p+2, p+3 (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // scan from the far end so the nearest candidate is written last and wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    state_t           state;
    state_t           state_n;
    logic [1:0]       ptr;
    logic [1:0]       ptr_n;
    logic [1:0]       owner_n;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             timeout_n;
    logic [2:0]       pick;
    logic [3:0]       mux_y;

    // next-state: arbitration from idle/backoff, hold accounting and release/timeout handling
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = select;
        cnt_n     = hold_cnt;
        timeout_n = 1'b0;
        pick      = rr_pick(req, ptr);
        case (state)
            ST_IDLE, ST_BACKOFF: begin
                if (pick[2]) begin
                    state_n = ST_GRANT;
                    owner_n = pick[1:0];
                    cnt_n   = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (req[select]) begin
                    if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        state_n   = ST_BACKOFF;
                        timeout_n = 1'b1;
                        ptr_n     = select + 2'd1;
                        cnt_n     = '0;
                    end else begin
                        cnt_n = hold_cnt + CNT_W'(1);
                    end
                end else begin
                    // released owner is masked out and the scan starts just past it
                    ptr_n = select + 2'd1;
                    pick  = rr_pick(req & ~(4'b0001 << select), select + 2'd1);
                    cnt_n = '0;
                    if (pick[2]) begin
                        owner_n = pick[1:0];
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // state register plus registered grant/select/valid/timeout outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            select   <= 2'd0;
            grant    <= 4'b0000;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= cnt_n;
            select   <= owner_n;
            grant    <= (state_n == ST_GRANT) ? (4'b0001 << owner_n) : 4'b0000;
            valid    <= (state_n == ST_GRANT);
            timeout  <= timeout_n;
        end
    end

    rr_mux_arbiter_mux u_mux (
        .a   (A),
        .b   (B),
        .c   (C),
        .d   (D),
        .sel (select),
        .y   (mux_y)
    );

    // the bus is quiet whenever nobody owns it
    always_comb begin
        y = valid ? mux_y : 4'h0;
    end

endmodule
